iq_readout_seq: RTL

//  Read-side sequencer for the 8K x 32b IQ sampler buffer. Runs in the sampler's rd_clk domain.
//  On a start command it pulses rd_sync with a programmed offset, primes the BRAM read path and

---
 rtl/iq_readout_seq.sv | 117 +++++++++++
 1 files changed

// File: rtl/iq_readout_seq.sv
// Read-side sequencer for the IQ sampler buffer: syncs the read pointer, primes the BRAM and
// streams N IQ pairs as interleaved I/Q 16-bit words over valid/ready.
module iq_readout_seq #(
  parameter int unsigned AW = 13,
  parameter int unsigned CW = 14
) (
  input  logic          rd_clk,
  input  logic          rd_rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] count,
  input  logic [AW-1:0] offset,
  output logic          busy,
  output logic          done,
  output logic          rd_sync,
  output logic          rd_i,
  output logic          rd_q,
  output logic [AW-1:0] rd_offset,
  input  logic [15:0]   rd_iq,
  output logic [15:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PRIME,
    EMIT_I,
    EMIT_Q
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] offset_nxt;
  logic          done_nxt;
  logic          cnt_one;

  assign cnt_one = (cnt == CW'(1));

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_offset <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rd_offset <= offset_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    offset_nxt = rd_offset;
    done_nxt   = 1'b0;
    busy       = (state != IDLE);
    rd_sync    = 1'b0;
    rd_i       = 1'b0;
    rd_q       = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = rd_iq;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          offset_nxt = offset;
          cnt_nxt    = (count == '0) ? (CW'(1) << AW) : CW'(count);
          state_nxt  = SYNC;
        end
      end
      SYNC: begin
        rd_sync   = 1'b1;
        state_nxt = PRIME;
      end
      PRIME: state_nxt = EMIT_I;
      EMIT_I: begin
        out_valid = 1'b1;
        rd_i      = 1'b1;
        if (out_ready) state_nxt = EMIT_Q;
      end
      EMIT_Q: begin
        out_valid = 1'b1;
        out_last  = cnt_one;
        // Address advances only when the Q word is taken, so stalls re-read the same pair.
        rd_q      = out_ready;
        if (out_ready) begin
          cnt_nxt = cnt - CW'(1);
          if (cnt_one) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = EMIT_I;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides every transition and withdraws the stream in the same cycle.
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      done_nxt  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      rd_q      = 1'b0;
      rd_sync   = 1'b0;
    end
  end

endmodule
